regwrite_arbiter: RTL and testbench
===================================

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Parameter: DATA_W, 64, width of write data.
REQ-002 Parameter: CNT_W, 16, width of committed-write counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; state clears on a rising edge of clk while reset=0.
REQ-005 hold  input  1  freeze: no grants while 1.
REQ-006 alu_valid  input  1  ALU writeback request.
REQ-007 alu_reg  input  5  ALU destination register.
REQ-008 alu_data  input  DATA_W  ALU result.
REQ-009 alu_ready  output  1  ALU request granted this cycle.
REQ-010 mem_valid  input  1  load writeback request.
REQ-011 mem_reg  input  5  load destination register.
REQ-012 mem_data  input  DATA_W  load data.
REQ-013 mem_ready  output  1  load request granted this cycle.
REQ-014 RegWrite  output  1  register-file write enable; feeds the 5:32 write decoder.
REQ-015 WriteRegister  output  5  register-file write address.
REQ-016 WriteData  output  DATA_W  register-file write data.
REQ-017 last_grant  output  1  last granted requester: 0=ALU, 1=MEM.
REQ-018 wr_count  output  CNT_W  count of committed register-file writes.

Function
REQ-019 Handshake: a transfer occurs on a cycle where valid=1 and ready=1; the requester shall hold valid, reg and data stable until ready.
REQ-020 alu_ready and mem_ready are combinational from valids, hold and last_grant; at most one is 1 per cycle; both are 0 when hold=1 or reset=0.
REQ-021 One valid only: that requester is granted.
REQ-022 Both valid: grant the requester not equal to last_grant (round-robin); neither requester waits more than one grant.
REQ-023 last_grant updates to the granted requester on every grant; unchanged otherwise.
REQ-024 Latency: a transfer in cycle N drives RegWrite, WriteRegister and WriteData in cycle N+1 (registered outputs).
REQ-025 No transfer in cycle N: RegWrite=0 in cycle N+1; WriteRegister and WriteData hold their previous values.
REQ-026 Zero register: a transfer with reg=31 is accepted (ready=1); in cycle N+1, RegWrite=0 and WriteRegister=31 with the new data captured; it is not counted.
REQ-027 wr_count increments by 1 on each cycle RegWrite=1 is driven and wraps from all-ones to 0.
REQ-028 Same destination from both requesters in one cycle: no merge; round-robin grants one, and the other is granted on a later cycle.
REQ-029 hold rising mid-contention: pending requests stay pending, and last_grant is unchanged until hold falls.

Reset
REQ-030 While reset=0 at a clock edge: RegWrite=0, WriteRegister=0, WriteData=0, last_grant=1 (so ALU wins the first contention), wr_count=0.
REQ-031 Reset mid-operation: a transfer in the reset cycle is discarded; no write appears in the following cycle.

Verification
REQ-032 Single ALU: alu_valid=1, alu_reg=5, alu_data=0xAA after reset -> alu_ready=1 same cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=0xAA, wr_count=1.
REQ-033 Contention: both valid for 4 cycles after reset (alu_reg=1, mem_reg=2) -> grants ALU, MEM, ALU, MEM; RegWrite=1 each following cycle; last_grant sequence 0,1,0,1.
REQ-034 Zero register: mem_valid=1, mem_reg=31 -> mem_ready=1; next cycle RegWrite=0, wr_count unchanged.
REQ-035 hold: hold=1 with both valid for 3 cycles -> both ready=0, RegWrite=0; release -> round-robin resumes from the prior last_grant.
REQ-036 Reset mid-transfer: reset=0 in a cycle with alu_valid=1 -> next cycle all outputs are at REQ-030 values, with RegWrite=0.
REQ-037 Wrap: CNT_W=4, 16 writes to reg 3 -> wr_count returns to 0.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks onto the single register-file write port.
// Latency: grant is combinational in the request cycle; the write port is driven one cycle later.
// Backpressure: the losing requester (or both when hold=1 or reset=0) sees ready=0 and keeps valid asserted.
module regwrite_arbiter #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              alu_valid,
    input  logic [4:0]        alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [4:0]        mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              RegWrite,
    output logic [4:0]        WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              last_grant,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic              grantAlu;
    logic              grantMem;
    logic              xfer;
    logic              doWrite;
    logic [4:0]        selReg;
    logic [DATA_W-1:0] selData;

    // last_grant=1 means MEM won last, so ALU has priority on the next contention.
    always_comb begin
        grantAlu = 1'b0;
        grantMem = 1'b0;
        if (reset && !hold) begin
            if (alu_valid && (!mem_valid || last_grant)) begin
                grantAlu = 1'b1;
            end else if (mem_valid) begin
                grantMem = 1'b1;
            end
        end
        xfer    = grantAlu | grantMem;
        selReg  = grantMem ? mem_reg  : alu_reg;
        selData = grantMem ? mem_data : alu_data;
        doWrite = xfer && (selReg != ZERO_REG);
    end

    assign alu_ready = grantAlu;
    assign mem_ready = grantMem;

    // A transfer to the zero register still updates address/data but never asserts the write enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            last_grant    <= 1'b1;
            wr_count      <= '0;
        end else begin
            RegWrite <= doWrite;
            if (xfer) begin
                WriteRegister <= selReg;
                WriteData     <= selData;
                last_grant    <= grantMem;
            end
            if (doWrite) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: inputs change and outputs are sampled around the falling edge.
module tb_regwrite_arbiter;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              hold;
    logic              alu_valid;
    logic [4:0]        alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [4:0]        mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              RegWrite;
    logic [4:0]        WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              last_grant;
    logic [CNT_W-1:0]  wr_count;

    int nChecks = 0;
    int nFails  = 0;

    regwrite_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .alu_valid    (alu_valid),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_reg      (mem_reg),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .last_grant   (last_grant),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReady(input string tag, input logic expAlu, input logic expMem);
        checkVal({tag, " alu_ready"}, 64'(alu_ready), 64'(expAlu));
        checkVal({tag, " mem_ready"}, 64'(mem_ready), 64'(expMem));
    endtask

    task automatic checkOut(input string tag, input logic expWe, input logic [4:0] expReg,
                            input logic [63:0] expData, input logic expLg, input int expCnt);
        checkVal({tag, " RegWrite"},      64'(RegWrite),      64'(expWe));
        checkVal({tag, " WriteRegister"}, 64'(WriteRegister), 64'(expReg));
        checkVal({tag, " WriteData"},     WriteData,          expData);
        checkVal({tag, " last_grant"},    64'(last_grant),    64'(expLg));
        checkVal({tag, " wr_count"},      64'(wr_count),      64'(expCnt));
    endtask

    initial begin
        reset     = 1'b0;
        hold      = 1'b0;
        alu_valid = 1'b1;
        alu_reg   = 5'd7;
        alu_data  = 64'h55;
        mem_valid = 1'b0;
        mem_reg   = 5'd0;
        mem_data  = '0;

        // Reset state; a valid request during reset must not be granted.
        repeat (2) @(negedge clk);
        #1 checkReady("in_reset", 1'b0, 1'b0);
        checkOut("reset_state", 1'b0, 5'd0, 64'h0, 1'b1, 0);

        // Single ALU write.
        @(negedge clk);
        reset    = 1'b1;
        alu_reg  = 5'd5;
        alu_data = 64'hAA;
        #1 checkReady("single_alu", 1'b1, 1'b0);
        @(negedge clk);
        alu_valid = 1'b0;
        checkOut("single_alu_wr", 1'b1, 5'd5, 64'hAA, 1'b0, 1);
        #1 checkReady("idle", 1'b0, 1'b0);
        @(negedge clk);
        checkOut("idle_hold", 1'b0, 5'd5, 64'hAA, 1'b0, 1);

        // Reset mid-transfer discards the request and restores reset values.
        reset     = 1'b0;
        alu_valid = 1'b1;
        alu_reg   = 5'd7;
        alu_data  = 64'h55;
        #1 checkReady("reset_mid", 1'b0, 1'b0);
        @(negedge clk);
        checkOut("reset_mid_out", 1'b0, 5'd0, 64'h0, 1'b1, 0);

        // Contention: ALU wins first, then strict alternation.
        reset     = 1'b1;
        alu_reg   = 5'd1;
        alu_data  = 64'h11;
        mem_valid = 1'b1;
        mem_reg   = 5'd2;
        mem_data  = 64'h22;
        for (int i = 0; i < 4; i++) begin
            logic expMem;
            expMem = (i % 2) == 1;
            #1 checkReady($sformatf("contend%0d", i), !expMem, expMem);
            @(negedge clk);
            if (i == 3) begin
                alu_valid = 1'b0;
                mem_valid = 1'b0;
            end
            checkOut($sformatf("contend%0d_wr", i), 1'b1, expMem ? 5'd2 : 5'd1,
                     expMem ? 64'h22 : 64'h11, expMem, i + 1);
        end

        // Hold with both valid to the same register; round-robin resumes from last_grant=1.
        hold      = 1'b1;
        alu_valid = 1'b1;
        alu_reg   = 5'd9;
        alu_data  = 64'h99;
        mem_valid = 1'b1;
        mem_reg   = 5'd9;
        mem_data  = 64'h77;
        for (int i = 0; i < 3; i++) begin
            #1 checkReady($sformatf("hold%0d", i), 1'b0, 1'b0);
            @(negedge clk);
            checkOut($sformatf("hold%0d_out", i), 1'b0, 5'd2, 64'h22, 1'b1, 4);
        end
        hold = 1'b0;
        #1 checkReady("release0", 1'b1, 1'b0);
        @(negedge clk);
        alu_valid = 1'b0;
        checkOut("release0_wr", 1'b1, 5'd9, 64'h99, 1'b0, 5);
        #1 checkReady("release1", 1'b0, 1'b1);
        @(negedge clk);
        mem_valid = 1'b0;
        checkOut("release1_wr", 1'b1, 5'd9, 64'h77, 1'b1, 6);

        // Zero register: accepted, captured, but not written or counted.
        mem_valid = 1'b1;
        mem_reg   = 5'd31;
        mem_data  = 64'hDEAD;
        #1 checkReady("zero_reg", 1'b0, 1'b1);
        @(negedge clk);
        mem_valid = 1'b0;
        checkOut("zero_reg_out", 1'b0, 5'd31, 64'hDEAD, 1'b1, 6);

        // Counter wrap: 16 writes to reg 3 after reset bring a 4-bit count back to 0.
        reset = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        alu_valid = 1'b1;
        alu_reg   = 5'd3;
        for (int i = 0; i < 16; i++) begin
            alu_data = 64'(i + 256);
            #1 checkReady($sformatf("wrap%0d", i), 1'b1, 1'b0);
            @(negedge clk);
            if (i == 14) checkVal("wrap_at_15", 64'(wr_count), 64'd15);
        end
        alu_valid = 1'b0;
        checkOut("wrap_end", 1'b1, 5'd3, 64'd271, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
